// File: rtl/mc_control.sv
// Multi-cycle control FSM for the 32-bit core: decodes opcode/funct, drives the
// datapath strobes, sequences memory accesses and counts retired instructions.
module mc_control #(
  parameter bit TRAP_ON_OF = 1'b1,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             of,
  input  logic             mem_ready,
  output logic [2:0]       alu_op,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             trap,
  output logic [CNT_W-1:0] retired
);

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEM_ADDR = 4'd2;
  localparam logic [3:0] MEM_RD   = 4'd3;
  localparam logic [3:0] MEM_WB   = 4'd4;
  localparam logic [3:0] MEM_WR   = 4'd5;
  localparam logic [3:0] EXEC_R   = 4'd6;
  localparam logic [3:0] EXEC_I   = 4'd7;
  localparam logic [3:0] ALU_WB   = 4'd8;
  localparam logic [3:0] BRANCH   = 4'd9;
  localparam logic [3:0] JUMP     = 4'd10;
  localparam logic [3:0] TRAP     = 4'd11;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  logic [3:0] state;
  logic [3:0] next_state;
  logic [2:0] r_op;
  logic       funct_ok;
  logic [2:0] exec_op;
  logic       is_arith;
  logic       of_trap;
  logic       retire;

  // IR is stable for the whole instruction, so ALU_WB re-derives the EXEC op
  // from opcode/funct and the overflow flag stays meaningful there.
  always_comb begin
    r_op     = ALU_ADD;
    funct_ok = 1'b1;
    case (funct)
      FN_ADD:  r_op = ALU_ADD;
      FN_SUB:  r_op = ALU_SUB;
      FN_AND:  r_op = ALU_AND;
      FN_OR:   r_op = ALU_OR;
      FN_SLT:  r_op = ALU_SLT;
      default: funct_ok = 1'b0;
    endcase
  end

  assign exec_op  = (opcode == OP_RTYPE) ? r_op : ALU_ADD;
  assign is_arith = ((opcode == OP_RTYPE) && ((funct == FN_ADD) || (funct == FN_SUB)))
                    || (opcode == OP_ADDI);
  assign of_trap  = TRAP_ON_OF && of && is_arith;

  always_comb begin
    next_state = state;
    case (state)
      FETCH:    next_state = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_RTYPE:     next_state = EXEC_R;
          OP_LW, OP_SW: next_state = MEM_ADDR;
          OP_BEQ:       next_state = BRANCH;
          OP_J:         next_state = JUMP;
          OP_ADDI:      next_state = EXEC_I;
          default:      next_state = TRAP;
        endcase
      end
      EXEC_R:   next_state = funct_ok ? ALU_WB : TRAP;
      EXEC_I:   next_state = ALU_WB;
      ALU_WB:   next_state = of_trap ? TRAP : FETCH;
      MEM_ADDR: next_state = (opcode == OP_SW) ? MEM_WR : MEM_RD;
      MEM_RD:   next_state = mem_ready ? MEM_WB : MEM_RD;
      MEM_WB:   next_state = FETCH;
      MEM_WR:   next_state = mem_ready ? FETCH : MEM_WR;
      BRANCH:   next_state = FETCH;
      JUMP:     next_state = FETCH;
      TRAP:     next_state = FETCH;
      default:  next_state = FETCH;
    endcase
  end

  // Strobes depend only on state (plus the handshake/flag qualifiers), so
  // reset immediately presents the FETCH decode and kills any write strobe.
  always_comb begin
    alu_op     = 3'b000;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'd0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    trap       = 1'b0;
    case (state)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        alu_op    = ALU_ADD;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      DECODE: begin
        alu_src_b = 2'd3;
        alu_op    = ALU_ADD;
      end
      EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = r_op;
      end
      EXEC_I, MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        alu_op    = ALU_ADD;
      end
      ALU_WB: begin
        alu_op    = exec_op;
        reg_dst   = (opcode == OP_RTYPE);
        reg_write = ~of_trap;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = 2'd1;
        pc_write  = zero;
      end
      JUMP: begin
        pc_src   = 2'd2;
        pc_write = 1'b1;
      end
      TRAP: begin
        trap     = 1'b1;
        pc_src   = 2'd3;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  assign retire = ((state == ALU_WB) && !of_trap) || (state == MEM_WB)
                  || ((state == MEM_WR) && mem_ready) || (state == BRANCH)
                  || (state == JUMP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired <= '0;
    end else if (retire) begin
      retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: a trapping 32-bit-counter instance and a
// non-trapping 3-bit-counter instance share stimulus; expected strobes come from the state tables.
module tb_mc_control;

  typedef struct packed {
    logic [16:0] vec;
    logic [16:0] mask;
    logic [16:0] nt_vec;
    logic [31:0] ret;
    logic [2:0]  ret_nt;
  } exp_t;

  localparam logic [16:0] FULL = 17'h1FFFF;

  logic        clk;
  logic        rst_n;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        of;
  logic        mem_ready;

  logic [2:0]  alu_op, alu_op_nt;
  logic        alu_src_a, alu_src_a_nt;
  logic [1:0]  alu_src_b, alu_src_b_nt;
  logic        iord, iord_nt;
  logic        mem_read, mem_read_nt;
  logic        mem_write, mem_write_nt;
  logic        ir_write, ir_write_nt;
  logic        pc_write, pc_write_nt;
  logic [1:0]  pc_src, pc_src_nt;
  logic        reg_dst, reg_dst_nt;
  logic        mem_to_reg, mem_to_reg_nt;
  logic        reg_write, reg_write_nt;
  logic        trap, trap_nt;
  logic [31:0] retired;
  logic [2:0]  retired_nt;

  logic [16:0] dut_vec, nt_vec;

  exp_t        q[$];
  string       tq[$];
  logic [31:0] exp_ret;
  logic [2:0]  exp_ret_nt;
  int          n_checks;
  int          n_fail;

  mc_control #(.TRAP_ON_OF(1'b1), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero), .of(of),
    .mem_ready(mem_ready), .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .trap(trap), .retired(retired)
  );

  mc_control #(.TRAP_ON_OF(1'b0), .CNT_W(3)) dut_nt (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero), .of(of),
    .mem_ready(mem_ready), .alu_op(alu_op_nt), .alu_src_a(alu_src_a_nt),
    .alu_src_b(alu_src_b_nt), .iord(iord_nt), .mem_read(mem_read_nt),
    .mem_write(mem_write_nt), .ir_write(ir_write_nt), .pc_write(pc_write_nt),
    .pc_src(pc_src_nt), .reg_dst(reg_dst_nt), .mem_to_reg(mem_to_reg_nt),
    .reg_write(reg_write_nt), .trap(trap_nt), .retired(retired_nt)
  );

  assign dut_vec = {alu_op, alu_src_a, alu_src_b, iord, mem_read, mem_write, ir_write,
                    pc_write, pc_src, reg_dst, mem_to_reg, reg_write, trap};
  assign nt_vec  = {alu_op_nt, alu_src_a_nt, alu_src_b_nt, iord_nt, mem_read_nt,
                    mem_write_nt, ir_write_nt, pc_write_nt, pc_src_nt, reg_dst_nt,
                    mem_to_reg_nt, reg_write_nt, trap_nt};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] v(input logic [2:0] aop, input logic sa, input logic [1:0] sb,
                                    input logic io, input logic mrd, input logic mwr,
                                    input logic irw, input logic pcw, input logic [1:0] pcs,
                                    input logic rd, input logic m2r, input logic rw,
                                    input logic tr);
    return {aop, sa, sb, io, mrd, mwr, irw, pcw, pcs, rd, m2r, rw, tr};
  endfunction

  function automatic logic [16:0] sFetch(input logic mr);
    return v(3'b010, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0, mr, mr, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [16:0] sDecode();
    return v(3'b010, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [16:0] sExecR(input logic [2:0] aop);
    return v(aop, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [16:0] sAddrImm();
    return v(3'b010, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [16:0] sAluWb(input logic [2:0] aop, input logic rd, input logic rw);
    return v(aop, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, rd, 1'b0, rw, 1'b0);
  endfunction
  function automatic logic [16:0] sMemRd();
    return v(3'b000, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [16:0] sMemWb();
    return v(3'b000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0);
  endfunction
  function automatic logic [16:0] sMemWr();
    return v(3'b000, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [16:0] sBranch(input logic z);
    return v(3'b110, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, z, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [16:0] sJump();
    return v(3'b000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [16:0] sTrap();
    return v(3'b000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  // Called just after a rising edge: drives this cycle's inputs, queues what both
  // instances must show before the next edge, then advances the retire model.
  task automatic applyStimulus(input string tag, input logic z, input logic o, input logic mr,
                               input logic [16:0] ev, input logic [16:0] mask,
                               input logic [16:0] env, input logic ret, input logic ret_nt);
    exp_t e;
    zero = z;
    of = o;
    mem_ready = mr;
    e.vec = ev;
    e.mask = mask;
    e.nt_vec = env;
    e.ret = exp_ret;
    e.ret_nt = exp_ret_nt;
    q.push_back(e);
    tq.push_back(tag);
    @(posedge clk);
    #1;
    if (ret) exp_ret = exp_ret + 32'd1;
    if (ret_nt) exp_ret_nt = exp_ret_nt + 3'd1;
  endtask

  task automatic step(input string tag, input logic z, input logic o, input logic mr,
                      input logic [16:0] ev, input logic ret);
    applyStimulus(tag, z, o, mr, ev, FULL, ev, ret, ret);
  endtask

  task automatic runR(input string tag, input logic [5:0] fn, input logic [2:0] aop,
                      input logic o);
    opcode = 6'h00;
    funct = fn;
    step({tag, ".fetch"}, 1'b0, o, 1'b1, sFetch(1'b1), 1'b0);
    step({tag, ".decode"}, 1'b0, o, 1'b1, sDecode(), 1'b0);
    step({tag, ".exec"}, 1'b0, o, 1'b1, sExecR(aop), 1'b0);
    step({tag, ".wb"}, 1'b0, o, 1'b1, sAluWb(aop, 1'b1, 1'b1), 1'b1);
  endtask

  // Overflowing add/sub/addi: the trapping instance suppresses writeback and
  // traps, the other one writes and retires, then idles in FETCH until re-aligned.
  task automatic runOverflow(input string tag, input logic [5:0] op, input logic [5:0] fn,
                             input logic [2:0] aop);
    logic rd;
    rd = (op == 6'h00);
    opcode = op;
    funct = fn;
    step({tag, ".fetch"}, 1'b0, 1'b1, 1'b1, sFetch(1'b1), 1'b0);
    step({tag, ".decode"}, 1'b0, 1'b1, 1'b1, sDecode(), 1'b0);
    if (rd) step({tag, ".exec"}, 1'b0, 1'b1, 1'b1, sExecR(aop), 1'b0);
    else    step({tag, ".exec"}, 1'b0, 1'b1, 1'b1, sAddrImm(), 1'b0);
    applyStimulus({tag, ".wb"}, 1'b0, 1'b1, 1'b1, sAluWb(aop, rd, 1'b0), FULL,
                  sAluWb(aop, rd, 1'b1), 1'b0, 1'b1);
    applyStimulus({tag, ".trap"}, 1'b0, 1'b0, 1'b0, sTrap(), FULL, sFetch(1'b0), 1'b0, 1'b0);
    step({tag, ".idle"}, 1'b0, 1'b0, 1'b0, sFetch(1'b0), 1'b0);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t  e;
      string t;
      e = q.pop_front();
      t = tq.pop_front();
      checkOutput({t, "/ctrl"}, {15'b0, dut_vec & e.mask}, {15'b0, e.vec & e.mask});
      checkOutput({t, "/ctrl_nt"}, {15'b0, nt_vec & e.mask}, {15'b0, e.nt_vec & e.mask});
      checkOutput({t, "/retired"}, retired, e.ret);
      checkOutput({t, "/retired_nt"}, {29'b0, retired_nt}, {29'b0, e.ret_nt});
      checkOutput({t, "/rd_wr_excl"}, {31'b0, mem_read & mem_write}, 32'd0);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail = 0;
    exp_ret = 32'd0;
    exp_ret_nt = 3'd0;
    rst_n = 1'b0;
    opcode = 6'h00;
    funct = 6'h00;
    zero = 1'b0;
    of = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    step("reset0", 1'b0, 1'b0, 1'b0, sFetch(1'b0), 1'b0);
    step("reset1", 1'b0, 1'b0, 1'b0, sFetch(1'b0), 1'b0);
    rst_n = 1'b1;
    step("idle", 1'b0, 1'b0, 1'b0, sFetch(1'b0), 1'b0);

    runR("add", 6'h20, 3'b010, 1'b0);

    opcode = 6'h23;
    funct = 6'h00;
    step("lw.fetch", 1'b0, 1'b0, 1'b1, sFetch(1'b1), 1'b0);
    step("lw.decode", 1'b0, 1'b0, 1'b1, sDecode(), 1'b0);
    step("lw.addr", 1'b0, 1'b0, 1'b1, sAddrImm(), 1'b0);
    for (int i = 0; i < 3; i++) step("lw.wait", 1'b0, 1'b0, 1'b0, sMemRd(), 1'b0);
    step("lw.rd", 1'b0, 1'b0, 1'b1, sMemRd(), 1'b0);
    step("lw.wb", 1'b0, 1'b0, 1'b1, sMemWb(), 1'b1);

    opcode = 6'h04;
    for (int i = 0; i < 2; i++) begin
      logic z;
      z = (i == 0);
      step("beq.fetch", z, 1'b0, 1'b1, sFetch(1'b1), 1'b0);
      step("beq.decode", z, 1'b0, 1'b1, sDecode(), 1'b0);
      step("beq.branch", z, 1'b0, 1'b1, sBranch(z), 1'b1);
    end

    opcode = 6'h02;
    step("j.fetch", 1'b0, 1'b0, 1'b1, sFetch(1'b1), 1'b0);
    step("j.decode", 1'b0, 1'b0, 1'b1, sDecode(), 1'b0);
    step("j.jump", 1'b0, 1'b0, 1'b1, sJump(), 1'b1);

    opcode = 6'h08;
    step("addi.fetch", 1'b0, 1'b0, 1'b1, sFetch(1'b1), 1'b0);
    step("addi.decode", 1'b0, 1'b0, 1'b1, sDecode(), 1'b0);
    step("addi.exec", 1'b0, 1'b0, 1'b1, sAddrImm(), 1'b0);
    step("addi.wb", 1'b0, 1'b0, 1'b1, sAluWb(3'b010, 1'b0, 1'b1), 1'b1);

    runR("and_of", 6'h24, 3'b000, 1'b1);
    runR("or", 6'h25, 3'b001, 1'b0);
    runR("slt_of", 6'h2A, 3'b111, 1'b1);
    runR("sub", 6'h22, 3'b110, 1'b0);

    opcode = 6'h2B;
    step("sw.fetch", 1'b0, 1'b0, 1'b1, sFetch(1'b1), 1'b0);
    step("sw.decode", 1'b0, 1'b0, 1'b1, sDecode(), 1'b0);
    step("sw.addr", 1'b0, 1'b0, 1'b1, sAddrImm(), 1'b0);
    step("sw.wr", 1'b0, 1'b0, 1'b1, sMemWr(), 1'b1);

    opcode = 6'h3F;
    step("badop.fetch", 1'b0, 1'b0, 1'b1, sFetch(1'b1), 1'b0);
    step("badop.decode", 1'b0, 1'b0, 1'b1, sDecode(), 1'b0);
    step("badop.trap", 1'b0, 1'b0, 1'b1, sTrap(), 1'b0);

    opcode = 6'h00;
    funct = 6'h00;
    step("badfn.fetch", 1'b0, 1'b0, 1'b1, sFetch(1'b1), 1'b0);
    step("badfn.decode", 1'b0, 1'b0, 1'b1, sDecode(), 1'b0);
    applyStimulus("badfn.exec", 1'b0, 1'b0, 1'b1, sExecR(3'b000), {3'b000, 14'h3FFF},
                  sExecR(3'b000), 1'b0, 1'b0);
    step("badfn.trap", 1'b0, 1'b0, 1'b1, sTrap(), 1'b0);

    step("stall0", 1'b0, 1'b0, 1'b0, sFetch(1'b0), 1'b0);
    step("stall1", 1'b0, 1'b0, 1'b0, sFetch(1'b0), 1'b0);

    runOverflow("sub_of", 6'h00, 6'h22, 3'b110);
    runOverflow("addi_of", 6'h08, 6'h00, 3'b010);
    runR("add_of_slt", 6'h2A, 3'b111, 1'b1);

    opcode = 6'h2B;
    funct = 6'h00;
    step("swr.fetch", 1'b0, 1'b0, 1'b1, sFetch(1'b1), 1'b0);
    step("swr.decode", 1'b0, 1'b0, 1'b1, sDecode(), 1'b0);
    step("swr.addr", 1'b0, 1'b0, 1'b1, sAddrImm(), 1'b0);
    step("swr.wait", 1'b0, 1'b0, 1'b0, sMemWr(), 1'b0);
    checkOutput("swr.before_rst/mem_write", {31'b0, mem_write}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("swr.async/mem_write", {31'b0, mem_write}, 32'd0);
    checkOutput("swr.async/ctrl", {15'b0, dut_vec}, {15'b0, sFetch(1'b0)});
    checkOutput("swr.async/retired", retired, 32'd0);
    checkOutput("swr.async/retired_nt", {29'b0, retired_nt}, 32'd0);
    exp_ret = 32'd0;
    exp_ret_nt = 3'd0;
    @(posedge clk);
    #1;
    step("swr.hold", 1'b0, 1'b0, 1'b0, sFetch(1'b0), 1'b0);
    rst_n = 1'b1;
    step("swr.idle", 1'b0, 1'b0, 1'b0, sFetch(1'b0), 1'b0);
    runR("post_rst_add", 6'h20, 3'b010, 1'b0);

    @(negedge clk);
    #1;
    checkOutput("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
